ps2_host_tx: RTL and testbench

//  PS/2 host-to-device transmitter; the send side of the keyboard port whose scancode receiver already exists.

---
 rtl/ps2_pkg.sv | 35 +++
 rtl/ps2_line_filter.sv | 78 +++++++
 rtl/ps2_host_tx.sv | 231 +++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg
//  Shared definitions for the PS/2 keyboard port: host transmitter state
//  encoding, default timing constants (48 MHz system clock), the frame
//  parity helper and a small constant-evaluation helper for counter sizing.
package ps2_pkg;

  // Host-to-device transmitter states.
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    INHIBIT    = 3'd1,
    REQ        = 3'd2,
    WAIT_FIRST = 3'd3,
    SHIFT      = 3'd4,
    ACK        = 3'd5,
    WAIT_IDLE  = 3'd6,
    FAIL       = 3'd7
  } ps2_tx_state_e;

  // Default timing at 48 MHz.
  localparam int DEF_INHIBIT_CYC = 6000;    // 125 us clock inhibit
  localparam int DEF_START_TMO   = 720000;  // 15 ms for the device to start clocking
  localparam int DEF_FRAME_TMO   = 96000;   // 2 ms from first edge to end of frame
  localparam int DEF_FILTER_LEN  = 8;       // stable samples before the clock changes

  // PS/2 uses odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

  // Larger of two integers, used when sizing counters from parameters.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter
//  Conditions the raw PS/2 pins for logic running on the system clock.
//  Both pins pass through a 2-flop synchroniser; the clock is then debounced
//  so it only changes after FILTER_LEN consecutive samples at the new level.
//  A one-cycle pulse marks each filtered 1->0 transition of the clock.
// Ports
//  clk         in   system clock
//  reset       in   synchronous, active-high
//  clk_raw_i   in   raw PS/2 clock pin (asynchronous)
//  dat_raw_i   in   raw PS/2 data pin (asynchronous)
//  clk_filt_o  out  debounced PS/2 clock
//  dat_sync_o  out  synchronised PS/2 data
//  fall_o      out  1-cycle pulse, coincident with clk_filt_o going low
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clk_raw_i,
  input  logic dat_raw_i,
  output logic clk_filt_o,
  output logic dat_sync_o,
  output logic fall_o
);

  localparam int FCNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]        clk_sync_q;
  logic [1:0]        dat_sync_q;
  logic              clk_filt_q;
  logic              clk_filt_d;
  logic [FCNT_W-1:0] fcnt_q;
  logic [FCNT_W-1:0] fcnt_d;
  logic              fall_q;

  // Synchronisers; the idle bus is high, so reset to 1 to avoid a false edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
    end else begin
      clk_sync_q <= {clk_sync_q[0], clk_raw_i};
      dat_sync_q <= {dat_sync_q[0], dat_raw_i};
    end
  end

  // Debounce: count consecutive samples that disagree with the filtered value.
  always_comb begin
    clk_filt_d = clk_filt_q;
    fcnt_d     = fcnt_q;
    if (clk_sync_q[1] == clk_filt_q) begin
      fcnt_d = '0;
    end else if (fcnt_q == FCNT_W'(FILTER_LEN - 1)) begin
      clk_filt_d = clk_sync_q[1];
      fcnt_d     = '0;
    end else begin
      fcnt_d = fcnt_q + FCNT_W'(1);
    end
  end

  // Filter state and falling-edge pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_filt_q <= 1'b1;
      fcnt_q     <= '0;
      fall_q     <= 1'b0;
    end else begin
      clk_filt_q <= clk_filt_d;
      fcnt_q     <= fcnt_d;
      fall_q     <= clk_filt_q & ~clk_filt_d;
    end
  end

  assign clk_filt_o = clk_filt_q;
  assign dat_sync_o = dat_sync_q[1];
  assign fall_o     = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx
//  PS/2 host-to-device transmitter. Sends one command byte per request using
//  the open-drain host-request sequence (inhibit clock, assert start bit,
//  release clock, shift bits on device falling edges) and reports whether the
//  device acknowledged. rx_inhibit stays high while a frame is in progress so
//  the neighbouring scancode receiver ignores the host's own traffic.
//  The pad wrapper drives a line low when its *_oe is 1, otherwise 'z'.
// Ports
//  clk         in   system clock
//  reset       in   synchronous, active-high
//  tx_data     in   command byte, latched on accept
//  tx_valid    in   request; accepted when tx_valid & tx_ready
//  tx_ready    out  high only when idle and out of reset
//  tx_done     out  1-cycle pulse at end of frame (ACK or NACK)
//  tx_ack_ok   out  valid with tx_done; 1 = device acknowledged
//  tx_error    out  1-cycle pulse on timeout (no tx_done for that frame)
//  rx_inhibit  out  high whenever not idle
//  ps2_clk_i   in   raw PS/2 clock pin
//  ps2_dat_i   in   raw PS/2 data pin
//  ps2_clk_oe  out  1 = pull PS/2 clock low
//  ps2_dat_oe  out  1 = pull PS/2 data low
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYC = DEF_INHIBIT_CYC,
  parameter int START_TMO   = DEF_START_TMO,
  parameter int FRAME_TMO   = DEF_FRAME_TMO,
  parameter int FILTER_LEN  = DEF_FILTER_LEN
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_ack_ok,
  output logic       tx_error,
  output logic       rx_inhibit,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  // One counter serves all three intervals; sized so it cannot wrap before
  // the longest of them expires.
  localparam int TMO_MAX = max_int(max_int(START_TMO, FRAME_TMO), INHIBIT_CYC);
  localparam int CNT_W   = $clog2(TMO_MAX + 1);

  ps2_tx_state_e state_q, state_d;
  logic [9:0]       shreg_q, shreg_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             ack_q, ack_d;
  logic             clk_oe_q, clk_oe_d;
  logic             dat_oe_q, dat_oe_d;
  logic             tx_ready_q, tx_done_q, tx_ack_ok_q, tx_error_q, rx_inhibit_q;
  logic             clk_filt_s, dat_sync_s, fall_s;
  logic             frame_tmo_s;

  ps2_line_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .clk        (clk),
    .reset      (reset),
    .clk_raw_i  (ps2_clk_i),
    .dat_raw_i  (ps2_dat_i),
    .clk_filt_o (clk_filt_s),
    .dat_sync_o (dat_sync_s),
    .fall_o     (fall_s)
  );

  assign cnt_inc_s   = cnt_q + CNT_W'(1);
  assign frame_tmo_s = (cnt_q == CNT_W'(FRAME_TMO - 1));

  // Next-state, datapath and pin-drive logic.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    cnt_d     = cnt_q;
    ack_d     = ack_q;
    clk_oe_d  = clk_oe_q;
    dat_oe_d  = dat_oe_q;
    case (state_q)
      IDLE: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        if (tx_valid && tx_ready_q) begin
          shreg_d   = {1'b1, odd_parity(tx_data), tx_data};
          bit_cnt_d = 4'd0;
          cnt_d     = '0;
          ack_d     = 1'b0;
          clk_oe_d  = 1'b1;  // clock is held low for every INHIBIT cycle
          state_d   = INHIBIT;
        end else begin
          state_d = IDLE;
        end
      end
      INHIBIT: begin
        clk_oe_d = 1'b1;
        if (cnt_q == CNT_W'(INHIBIT_CYC - 1)) begin
          dat_oe_d = 1'b1;  // start bit
          cnt_d    = '0;
          state_d  = REQ;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      REQ: begin
        // Data is already low; releasing the clock hands control to the device.
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b1;
        cnt_d    = '0;
        state_d  = WAIT_FIRST;
      end
      WAIT_FIRST: begin
        if (fall_s) begin
          dat_oe_d  = ~shreg_q[0];
          shreg_d   = {1'b1, shreg_q[9:1]};
          bit_cnt_d = 4'd1;
          cnt_d     = '0;  // frame timer starts at the first edge
          state_d   = SHIFT;
        end else if (cnt_q == CNT_W'(START_TMO - 1)) begin
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b0;
          state_d  = FAIL;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      SHIFT: begin
        if (frame_tmo_s) begin
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b0;
          state_d  = FAIL;
        end else if (fall_s) begin
          dat_oe_d  = ~shreg_q[0];
          shreg_d   = {1'b1, shreg_q[9:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          cnt_d     = cnt_inc_s;
          // bit_cnt_q == 9 means this edge drives the stop bit.
          if (bit_cnt_q == 4'd9) begin
            state_d = ACK;
          end else begin
            state_d = SHIFT;
          end
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      ACK: begin
        dat_oe_d = 1'b0;
        if (frame_tmo_s) begin
          clk_oe_d = 1'b0;
          state_d  = FAIL;
        end else if (fall_s) begin
          ack_d   = ~dat_sync_s;
          cnt_d   = cnt_inc_s;
          state_d = WAIT_IDLE;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      WAIT_IDLE: begin
        dat_oe_d = 1'b0;
        if (frame_tmo_s) begin
          clk_oe_d = 1'b0;
          state_d  = FAIL;
        end else if (clk_filt_s && dat_sync_s) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      FAIL: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        state_d  = IDLE;
      end
      default: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs. Reset releases both lines at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= 4'd0;
      cnt_q        <= '0;
      ack_q        <= 1'b0;
      clk_oe_q     <= 1'b0;
      dat_oe_q     <= 1'b0;
      tx_ready_q   <= 1'b0;
      tx_done_q    <= 1'b0;
      tx_ack_ok_q  <= 1'b0;
      tx_error_q   <= 1'b0;
      rx_inhibit_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      cnt_q        <= cnt_d;
      ack_q        <= ack_d;
      clk_oe_q     <= clk_oe_d;
      dat_oe_q     <= dat_oe_d;
      // Ready needs a full idle cycle behind it, so it rises one cycle after
      // tx_done/tx_error and drops right after an accept.
      tx_ready_q   <= (state_q == IDLE) && (state_d == IDLE);
      tx_done_q    <= (state_q == WAIT_IDLE) && (state_d == IDLE);
      tx_ack_ok_q  <= (state_q == WAIT_IDLE) && (state_d == IDLE) && ack_q;
      tx_error_q   <= (state_q == FAIL);
      rx_inhibit_q <= (state_d != IDLE);
    end
  end

  assign tx_ready   = tx_ready_q;
  assign tx_done    = tx_done_q;
  assign tx_ack_ok  = tx_ack_ok_q;
  assign tx_error   = tx_error_q;
  assign rx_inhibit = rx_inhibit_q;
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx
//  Directed bench for ps2_host_tx with a simple PS/2 device model that clocks
//  at 20 system cycles per half period, samples data at the end of each low
//  phase and optionally acknowledges.
module tb_ps2_host_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, tx_done, tx_ack_ok, tx_error, rx_inhibit;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic       bfm_clk_low, bfm_dat_low;
  logic       clk_line, dat_line;

  int checks   = 0;
  int failures = 0;
  int done_total = 0;
  int err_total  = 0;

  // Open-drain bus: either side may pull low.
  assign clk_line = ~(ps2_clk_oe | bfm_clk_low);
  assign dat_line = ~(ps2_dat_oe | bfm_dat_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYC (40),
    .START_TMO   (500),
    .FRAME_TMO   (2000),
    .FILTER_LEN  (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_done    (tx_done),
    .tx_ack_ok  (tx_ack_ok),
    .tx_error   (tx_error),
    .rx_inhibit (rx_inhibit),
    .ps2_clk_i  (clk_line),
    .ps2_dat_i  (dat_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe)
  );

  // Count completion and error pulses over the whole run.
  always @(negedge clk) begin
    if (tx_done === 1'b1) done_total <= done_total + 1;
    if (tx_error === 1'b1) err_total <= err_total + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic request(input logic [7:0] d, input logic hold);
    int n = 0;
    while (tx_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_req", {31'd0, tx_ready}, 32'd1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    if (!hold) tx_valid = 1'b0;
  endtask

  // Measure the clock-only inhibit time, then check the start-bit handover.
  task automatic inhibit_phase();
    int inh = 0;
    int n = 0;
    while (ps2_dat_oe !== 1'b1 && n < 200) begin
      if (ps2_clk_oe === 1'b1) inh++;
      @(negedge clk);
      n++;
    end
    check("inhibit_ge_40", {31'd0, (inh >= 40 && inh <= 42)}, 32'd1);
    check("clk_held_at_start", {31'd0, ps2_clk_oe}, 32'd1);
    @(negedge clk);
    check("clk_released", {31'd0, ps2_clk_oe}, 32'd0);
    check("start_bit_oe", {31'd0, ps2_dat_oe}, 32'd1);
    check("rx_inhibit_busy", {31'd0, rx_inhibit}, 32'd1);
  endtask

  task automatic clock_bits(input int nbits, input logic glitch, output logic [9:0] smp);
    smp = '0;
    for (int i = 0; i < nbits; i++) begin
      if (glitch && i == 4) begin
        bfm_clk_low = 1'b1;
        repeat (3) @(negedge clk);
        bfm_clk_low = 1'b0;
        repeat (15) @(negedge clk);
      end
      bfm_clk_low = 1'b1;
      repeat (20) @(negedge clk);
      smp[i] = dat_line;
      bfm_clk_low = 1'b0;
      repeat (20) @(negedge clk);
    end
  endtask

  task automatic ack_phase(input logic do_ack);
    bfm_clk_low = 1'b1;
    bfm_dat_low = do_ack;
    repeat (20) @(negedge clk);
    bfm_clk_low = 1'b0;
    repeat (5) @(negedge clk);
    bfm_dat_low = 1'b0;
  endtask

  task automatic finish_frame(input logic exp_ack, input string tag);
    int n = 0;
    logic inh_prev;
    inh_prev = rx_inhibit;
    while (tx_done !== 1'b1 && tx_error !== 1'b1 && n < 300) begin
      inh_prev = rx_inhibit;
      @(negedge clk);
      n++;
    end
    tx_valid = 1'b0;
    check({tag, "_done"}, {31'd0, tx_done}, 32'd1);
    check({tag, "_no_error"}, {31'd0, tx_error}, 32'd0);
    check({tag, "_ack_ok"}, {31'd0, tx_ack_ok}, {31'd0, exp_ack});
    check({tag, "_inh_before"}, {31'd0, inh_prev}, 32'd1);
    check({tag, "_inh_falls"}, {31'd0, rx_inhibit}, 32'd0);
    check({tag, "_ready_low_at_done"}, {31'd0, tx_ready}, 32'd0);
    @(negedge clk);
    check({tag, "_ready_after"}, {31'd0, tx_ready}, 32'd1);
    check({tag, "_done_one_cycle"}, {31'd0, tx_done}, 32'd0);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [9:0] exp_bits,
                            input logic do_ack, input logic glitch, input logic hold,
                            input string tag);
    logic [9:0] smp;
    request(d, hold);
    inhibit_phase();
    repeat (30) @(negedge clk);
    check({tag, "_start_bit_line"}, {31'd0, dat_line}, 32'd0);
    clock_bits(10, glitch, smp);
    check({tag, "_bits"}, {22'd0, smp}, {22'd0, exp_bits});
    ack_phase(do_ack);
    finish_frame(do_ack, tag);
  endtask

  initial begin : main
    int n;
    int seen;
    int d0;
    int e0;
    logic [9:0] smp;

    reset       = 1'b1;
    tx_data     = 8'h00;
    tx_valid    = 1'b0;
    bfm_clk_low = 1'b0;
    bfm_dat_low = 1'b0;
    repeat (4) @(negedge clk);

    // Reset state: every output low.
    check("rst_ready", {31'd0, tx_ready}, 32'd0);
    check("rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
    check("rst_dat_oe", {31'd0, ps2_dat_oe}, 32'd0);
    check("rst_rx_inhibit", {31'd0, rx_inhibit}, 32'd0);
    check("rst_done", {31'd0, tx_done}, 32'd0);
    check("rst_error", {31'd0, tx_error}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", {31'd0, tx_ready}, 32'd1);

    // 0xED: bits 1,0,1,1,0,1,1,1, parity 1, stop 1.
    send_frame(8'hED, 10'h3ED, 1'b1, 1'b0, 1'b0, "ed");
    // 0x07: parity 0.  0x00: parity 1.
    send_frame(8'h07, 10'h207, 1'b1, 1'b0, 1'b0, "x07");
    send_frame(8'h00, 10'h300, 1'b1, 1'b0, 1'b0, "x00");
    // 0x55 with the device leaving data high at ACK time.
    send_frame(8'h55, 10'h355, 1'b0, 1'b0, 1'b0, "nack");

    // Device never clocks: timeout about 500 cycles after clock release.
    request(8'hF4, 1'b0);
    inhibit_phase();
    n = 1;
    while (tx_error !== 1'b1 && tx_done !== 1'b1 && n < 700) begin
      @(negedge clk);
      n++;
    end
    check("tmo_error", {31'd0, tx_error}, 32'd1);
    check("tmo_no_done", {31'd0, tx_done}, 32'd0);
    check("tmo_latency", {31'd0, (n >= 495 && n <= 510)}, 32'd1);
    check("tmo_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
    check("tmo_dat_oe", {31'd0, ps2_dat_oe}, 32'd0);
    @(negedge clk);
    check("tmo_ready_next", {31'd0, tx_ready}, 32'd1);
    check("tmo_error_one_cycle", {31'd0, tx_error}, 32'd0);

    // Reset during bit 4 of a 0xAB frame.
    request(8'hAB, 1'b0);
    inhibit_phase();
    repeat (30) @(negedge clk);
    clock_bits(4, 1'b0, smp);
    check("pre_reset_bits", {28'd0, smp[3:0]}, 32'hB);
    bfm_clk_low = 1'b1;
    repeat (15) @(negedge clk);
    check("bit4_driven", {31'd0, ps2_dat_oe}, 32'd1);
    d0 = done_total;
    e0 = err_total;
    reset = 1'b1;
    @(negedge clk);
    check("midrst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
    check("midrst_dat_oe", {31'd0, ps2_dat_oe}, 32'd0);
    check("midrst_ready", {31'd0, tx_ready}, 32'd0);
    check("midrst_rx_inhibit", {31'd0, rx_inhibit}, 32'd0);
    bfm_clk_low = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (50) @(negedge clk);
    check("midrst_no_done", done_total, d0);
    check("midrst_no_error", err_total, e0);
    send_frame(8'hFF, 10'h3FF, 1'b1, 1'b0, 1'b0, "ff");

    // Clock glitch mid-frame and tx_valid held for the whole frame.
    send_frame(8'h5A, 10'h35A, 1'b1, 1'b1, 1'b1, "glitch");
    seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (ps2_clk_oe !== 1'b0) seen++;
    end
    check("held_valid_single_frame", seen, 0);

    repeat (3) @(negedge clk);
    check("total_done", done_total, 6);
    check("total_error", err_total, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: run exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

endmodule
